// File: rtl/upcnt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | upcnt_pkg                                                          |
// | Shared command bytes, run/stop state encoding and BCD limit.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package upcnt_pkg;

    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STOP  = 8'h53;
    localparam logic [7:0] CMD_CLEAR = 8'h43;

    typedef logic [0:0] state_t;
    localparam state_t ST_STOP = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage : upcnt_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_digit                                                          |
// | One decimal digit with synchronous clear and combinational carry.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bcd_digit
    import upcnt_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_carry_in,
    output logic [3:0] o_digit,
    output logic       o_carry_out
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Clear outranks an incoming carry so a cleared count never lands on 1.
    always_comb begin
        digit_d = digit_q;
        if (i_clear) begin
            digit_d = 4'd0;
        end else if (i_carry_in) begin
            digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    assign o_carry_out = i_carry_in && (digit_q == BCD_MAX);
    assign o_digit     = digit_q;

endmodule : bcd_digit
`default_nettype wire

// File: rtl/tick_bcd_upcounter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_bcd_upcounter                                                 |
// | Tick-driven packed-BCD up-counter with UART/button run-stop-clear. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tick_bcd_upcounter #(
    parameter int         DIGITS    = 4,
    parameter logic [7:0] CMD_RUN   = upcnt_pkg::CMD_RUN,
    parameter logic [7:0] CMD_STOP  = upcnt_pkg::CMD_STOP,
    parameter logic [7:0] CMD_CLEAR = upcnt_pkg::CMD_CLEAR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_tick,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_btn_run_stop,
    input  logic                  i_btn_clear,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_running,
    output logic                  o_wrap
);

    import upcnt_pkg::state_t;
    import upcnt_pkg::ST_STOP;
    import upcnt_pkg::ST_RUN;

    state_t state_q;
    state_t state_d;
    logic   wrap_q;
    logic   wrap_d;

    logic w_uart_run;
    logic w_uart_stop;
    logic w_uart_rs;
    logic w_btn_rs;
    logic w_start_req;
    logic w_stop_req;
    logic w_clear_req;
    logic [DIGITS:0] w_carry;

    // A UART run/stop byte masks a coincident button toggle.
    assign w_uart_run  = i_rx_valid && (i_rx_data == CMD_RUN);
    assign w_uart_stop = i_rx_valid && (i_rx_data == CMD_STOP);
    assign w_uart_rs   = w_uart_run || w_uart_stop;
    assign w_btn_rs    = !w_uart_rs && i_btn_run_stop;
    assign w_start_req = w_uart_run  || (w_btn_rs && (state_q == ST_STOP));
    assign w_stop_req  = w_uart_stop || (w_btn_rs && (state_q == ST_RUN));
    assign w_clear_req = (i_rx_valid && (i_rx_data == CMD_CLEAR)) || i_btn_clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (w_start_req) state_d = ST_RUN;
            ST_RUN:  if (w_stop_req)  state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    always_comb begin
        o_running = (state_q == ST_RUN);
    end

    // The tick is qualified by the state before this edge's transition.
    assign w_carry[0] = i_tick && (state_q == ST_RUN);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk         (clk),
            .reset       (reset),
            .i_clear     (w_clear_req),
            .i_carry_in  (w_carry[k]),
            .o_digit     (o_bcd[4*k +: 4]),
            .o_carry_out (w_carry[k+1])
        );
    end

    assign wrap_d = w_carry[DIGITS] && !w_clear_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign o_wrap = wrap_q;

endmodule : tick_bcd_upcounter
`default_nettype wire

// File: tb/tb_tick_bcd_upcounter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tick_bcd_upcounter                                              |
// | Directed vector table plus hand sequences for wrap/clear/reset.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_tick_bcd_upcounter;

    logic        clk;
    logic        reset;
    logic        i_tick;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_btn_run_stop;
    logic        i_btn_clear;
    logic [15:0] o_bcd;
    logic        o_running;
    logic        o_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    tick_bcd_upcounter #(.DIGITS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_tick         (i_tick),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .i_btn_run_stop (i_btn_run_stop),
        .i_btn_clear    (i_btn_clear),
        .o_bcd          (o_bcd),
        .o_running      (o_running),
        .o_wrap         (o_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tick;
        logic        rx_v;
        logic [7:0]  rx_d;
        logic        brs;
        logic        bclr;
        logic [15:0] bcd;
        logic        run;
        logic        wrap;
    } vec_t;

    vec_t tbl [0:21];

    task automatic check(input string name, input logic [15:0] bcd,
                         input logic run, input logic wrap);
        n_checks++;
        if (o_bcd !== bcd || o_running !== run || o_wrap !== wrap) begin
            n_fail++;
            $display("FAIL %s: got bcd=%h run=%b wrap=%b, expected bcd=%h run=%b wrap=%b",
                     name, o_bcd, o_running, o_wrap, bcd, run, wrap);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then release the strobes.
    task automatic cyc(input logic t, input logic rv, input logic [7:0] d,
                       input logic brs, input logic bclr);
        i_tick = t; i_rx_valid = rv; i_rx_data = d;
        i_btn_run_stop = brs; i_btn_clear = bclr;
        @(posedge clk);
        #1;
        i_tick = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
        i_btn_run_stop = 1'b0; i_btn_clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("reset_hold", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; i_tick = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
        i_btn_run_stop = 1'b0; i_btn_clear = 1'b0;

        //               tick rv  data   brs  bclr bcd       run  wrap
        tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,16'h0000,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,16'h0000,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,16'h0000,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,16'h0000,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,16'h0000,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b1,8'h52,1'b0,1'b0,16'h0000,1'b1,1'b0};
        tbl[6]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,16'h0001,1'b1,1'b0};
        tbl[7]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,16'h0002,1'b1,1'b0};
        tbl[8]  = '{1'b1,1'b1,8'h41,1'b0,1'b0,16'h0003,1'b1,1'b0};
        tbl[9]  = '{1'b1,1'b0,8'h53,1'b0,1'b0,16'h0004,1'b1,1'b0};
        tbl[10] = '{1'b1,1'b1,8'h53,1'b0,1'b0,16'h0005,1'b0,1'b0};
        tbl[11] = '{1'b1,1'b0,8'h00,1'b0,1'b0,16'h0005,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b1,8'h52,1'b0,1'b0,16'h0005,1'b1,1'b0};
        tbl[13] = '{1'b1,1'b1,8'h52,1'b0,1'b0,16'h0006,1'b1,1'b0};
        tbl[14] = '{1'b1,1'b1,8'h43,1'b0,1'b0,16'h0000,1'b1,1'b0};
        tbl[15] = '{1'b1,1'b0,8'h00,1'b1,1'b0,16'h0001,1'b0,1'b0};
        tbl[16] = '{1'b0,1'b1,8'h53,1'b1,1'b0,16'h0001,1'b0,1'b0};
        tbl[17] = '{1'b0,1'b0,8'h00,1'b1,1'b0,16'h0001,1'b1,1'b0};
        tbl[18] = '{1'b0,1'b1,8'h52,1'b1,1'b0,16'h0001,1'b1,1'b0};
        tbl[19] = '{1'b1,1'b0,8'h00,1'b0,1'b1,16'h0000,1'b1,1'b0};
        tbl[20] = '{1'b1,1'b1,8'h53,1'b0,1'b1,16'h0000,1'b0,1'b0};
        tbl[21] = '{1'b0,1'b1,8'h41,1'b0,1'b0,16'h0000,1'b0,1'b0};

        #12;
        check("reset_state", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].tick, tbl[i].rx_v, tbl[i].rx_d, tbl[i].brs, tbl[i].bclr);
            check($sformatf("vec%0d", i), tbl[i].bcd, tbl[i].run, tbl[i].wrap);
        end

        // Run 12 ticks, then stop and confirm ticks are ignored.
        do_reset();
        cyc(1'b0, 1'b1, 8'h52, 1'b0, 1'b0);
        ticks(12);
        check("run12", 16'h0012, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'h53, 1'b0, 1'b0);
        ticks(3);
        check("stop_hold", 16'h0012, 1'b0, 1'b0);

        // Multi-digit carry and full rollover.
        do_reset();
        cyc(1'b0, 1'b1, 8'h52, 1'b0, 1'b0);
        ticks(99);
        check("pre_0099", 16'h0099, 1'b1, 1'b0);
        ticks(1);
        check("carry_0100", 16'h0100, 1'b1, 1'b0);
        ticks(9899);
        check("pre_9999", 16'h9999, 1'b1, 1'b0);
        ticks(1);
        check("wrap_pulse", 16'h0000, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("wrap_drop", 16'h0000, 1'b1, 1'b0);

        // Clear beats a tick at all-9s: no wrap pulse.
        ticks(9999);
        check("pre_9999_b", 16'h9999, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("clear_at_9999", 16'h0000, 1'b1, 1'b0);

        // Clear coinciding with a tick at 0042.
        ticks(42);
        check("pre_0042", 16'h0042, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'h43, 1'b0, 1'b0);
        check("clear_tick", 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset mid-count.
        ticks(733);
        check("pre_0733", 16'h0733, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 16'h0000, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        ticks(4);
        check("no_resume", 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h52, 1'b0, 1'b0);
        ticks(1);
        check("resume", 16'h0001, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tick_bcd_upcounter
`default_nettype wire
